// File: rtl/prior_enco_rr_hs.sv
// Registered priority encoder with grant/ack handshake, fixed or round-robin
// priority and a saturating count of completed grants.
module prior_enco_rr_hs #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             rr_mode,
    input  logic             ack,
    output logic [IDX_W-1:0] dout,
    output logic [WIDTH-1:0] dout_oh,
    output logic             valid,
    output logic             any,
    output logic [CNT_W-1:0] grant_cnt
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           r_state, w_state_nx;
    logic [IDX_W-1:0] r_dout, w_dout_nx;
    logic [WIDTH-1:0] r_oh, w_oh_nx;
    logic [IDX_W-1:0] r_ptr, w_ptr_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [IDX_W-1:0] w_ptr_dec;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_win;
    logic             w_found;
    logic             w_acked;

    assign any       = |din;
    assign w_acked   = (r_state == S_HOLD) && ack;
    assign w_ptr_dec = (r_dout == '0) ? LAST : r_dout - 1'b1;
    assign w_ptr_nx  = w_acked ? w_ptr_dec : r_ptr;
    // Re-evaluation after an ack already sees the updated pointer.
    assign w_start   = rr_mode ? w_ptr_nx : LAST;

    always_comb begin
        int               w_k;
        logic [IDX_W-1:0] w_kx;
        w_found = 1'b0;
        w_win   = '0;
        w_k     = 0;
        w_kx    = '0;
        for (int j = 0; j < WIDTH; j++) begin
            w_k  = (int'(w_start) + WIDTH - j) % WIDTH;
            w_kx = IDX_W'(w_k);
            if (!w_found && din[w_kx]) begin
                w_found = 1'b1;
                w_win   = w_kx;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_dout_nx  = r_dout;
        w_oh_nx    = r_oh;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (en && w_found) begin
                    w_state_nx = S_HOLD;
                    w_dout_nx  = w_win;
                    w_oh_nx    = ONE << w_win;
                end
            end
            S_HOLD: begin
                if (ack) begin
                    if (r_cnt != '1) begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                    if (en && w_found) begin
                        w_dout_nx = w_win;
                        w_oh_nx   = ONE << w_win;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_dout  <= '0;
            r_oh    <= '0;
            r_ptr   <= LAST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_dout  <= w_dout_nx;
            r_oh    <= w_oh_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign dout      = r_dout;
    assign dout_oh   = r_oh;
    assign valid     = (r_state == S_HOLD);
    assign grant_cnt = r_cnt;

endmodule

// File: tb/tb_prior_enco_rr_hs.sv
// Bench for prior_enco_rr_hs: WIDTH=8 and WIDTH=5 instances against a
// behavioural grant model, plus directed scenarios with literal expectations.
module tb_prior_enco_rr_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [7:0] din8;
    logic [4:0] din5;
    logic       en8, en5, rr8, rr5, ack8, ack5;
    logic [2:0] dout8, dout5;
    logic [7:0] oh8;
    logic [4:0] oh5;
    logic       v8, v5, any8, any5;
    logic [15:0] cnt8;
    logic [1:0]  cnt5;

    prior_enco_rr_hs #(.WIDTH(8), .IDX_W(3), .CNT_W(16)) u8 (
        .clk(clk), .rst_n(rst_n), .din(din8), .en(en8), .rr_mode(rr8),
        .ack(ack8), .dout(dout8), .dout_oh(oh8), .valid(v8), .any(any8),
        .grant_cnt(cnt8)
    );

    prior_enco_rr_hs #(.WIDTH(5), .IDX_W(3), .CNT_W(2)) u5 (
        .clk(clk), .rst_n(rst_n), .din(din5), .en(en5), .rr_mode(rr5),
        .ack(ack5), .dout(dout5), .dout_oh(oh5), .valid(v5), .any(any5),
        .grant_cnt(cnt5)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: one slot per instance (0 -> WIDTH 8, 1 -> WIDTH 5)
    int m_w[2]    = '{8, 5};
    int m_cmax[2] = '{65535, 3};
    bit m_valid[2];
    int m_dout[2];
    int m_oh[2];
    int m_ptr[2];
    int m_cnt[2];
    int t6e[6]    = '{4, 3, 2, 1, 0, 4};

    function automatic int search(int w, int start, int d);
        for (int j = 0; j < w; j++) begin
            int k;
            k = (start - j + w) % w;
            if (((d >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    task automatic mreset(int i);
        m_valid[i] = 1'b0;
        m_dout[i]  = 0;
        m_oh[i]    = 0;
        m_cnt[i]   = 0;
        m_ptr[i]   = m_w[i] - 1;
    endtask

    task automatic mstep(int i, int d, bit e, bit rr, bit a);
        int k;
        if (m_valid[i]) begin
            if (!a) return;
            if (m_cnt[i] != m_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            m_ptr[i] = (m_dout[i] + m_w[i] - 1) % m_w[i];
        end
        k = e ? search(m_w[i], rr ? m_ptr[i] : m_w[i] - 1, d) : -1;
        if (k >= 0) begin
            m_valid[i] = 1'b1;
            m_dout[i]  = k;
            m_oh[i]    = 1 << k;
        end else begin
            m_valid[i] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0, int'(din8), en8, rr8, ack8);
            mstep(1, int'(din5), en5, rr5, ack5);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("valid8", 32'(v8), 32'(m_valid[0]));
        chk("dout8", 32'(dout8), m_dout[0]);
        chk("oh8", 32'(oh8), m_oh[0]);
        chk("any8", 32'(any8), 32'(din8 != 8'h00));
        chk("cnt8", 32'(cnt8), m_cnt[0]);
        chk("valid5", 32'(v5), 32'(m_valid[1]));
        chk("dout5", 32'(dout5), m_dout[1]);
        chk("oh5", 32'(oh5), m_oh[1]);
        chk("any5", 32'(any5), 32'(din5 != 5'h00));
        chk("cnt5", 32'(cnt5), m_cnt[1]);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    initial begin
        din8 = '0; din5 = '0;
        en8 = 0; en5 = 0; rr8 = 0; rr5 = 0; ack8 = 0; ack5 = 0;
        ticks(2);
        rst_n = 1'b1;

        // idle with no requests; ack while not valid is ignored
        en8 = 1; ack8 = 1;
        ticks(5);
        chk("t1_valid", 32'(v8), 0);
        chk("t1_dout", 32'(dout8), 0);
        chk("t1_any", 32'(any8), 0);
        chk("t1_cnt", 32'(cnt8), 0);

        // fixed priority, grant held while unacked
        ack8 = 0; din8 = 8'hA6;
        tick();
        chk("t2_dout", 32'(dout8), 7);
        chk("t2_oh", 32'(oh8), 32'h80);
        chk("t2_valid", 32'(v8), 1);
        din8 = 8'h01;
        ticks(3);
        chk("t2_hold", 32'(dout8), 7);
        chk("t2_hold_v", 32'(v8), 1);

        // fixed back-to-back
        din8 = 8'h0C; ack8 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_dout", 32'(dout8), 3);
            chk("t3_valid", 32'(v8), 1);
        end
        chk("t3_cnt", 32'(cnt8), 4);

        // round robin alternation and pointer wrap
        rr8 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_rr", 32'(dout8), (i % 2 == 0) ? 2 : 3);
        end
        din8 = 8'h81;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_wrap", 32'(dout8), (i % 2 == 0) ? 0 : 7);
        end
        chk("t4_cnt", 32'(cnt8), 12);

        // reset mid-hold
        en8 = 0;
        tick();
        ack8 = 0; rr8 = 0; en8 = 1; din8 = 8'h20;
        tick();
        chk("t5_dout", 32'(dout8), 5);
        chk("t5_valid", 32'(v8), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(v8), 0);
        chk("t5_rst_dout", 32'(dout8), 0);
        chk("t5_rst_oh", 32'(oh8), 0);
        chk("t5_rst_cnt", 32'(cnt8), 0);
        tick();
        rst_n = 1'b1; rr8 = 1; din8 = 8'h21;
        tick();
        chk("t5_resume", 32'(dout8), 5);
        ack8 = 1;
        tick();
        chk("t5_next", 32'(dout8), 0);

        // WIDTH=5 round robin, counter saturation
        ack8 = 0; en8 = 0;
        rr5 = 1; din5 = 5'h1F; en5 = 1; ack5 = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_dout", 32'(dout5), t6e[i]);
        end
        chk("t6_cnt", 32'(cnt5), 3);
        en5 = 0;
        ticks(2);
        chk("t6_idle_v", 32'(v5), 0);
        chk("t6_idle_cnt", 32'(cnt5), 3);

        // randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            din8 = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
            din5 = ($urandom % 4 == 0) ? 5'h00 : 5'($urandom);
            en8  = ($urandom % 5) != 0;
            en5  = ($urandom % 5) != 0;
            rr8  = 1'($urandom);
            rr5  = 1'($urandom);
            ack8 = 1'($urandom);
            ack5 = ($urandom % 3) != 0;
            if ($urandom % 150 == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
